// File: rtl/motor_fault_classifier_pkg.sv
// Shared types, defaults and the window classifier for the motor fault classifier.
// Fault encoding follows the motor signal generator's mode encoding.
package motor_fault_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WIN_LOG2 = 4;
    localparam int MEAN_HI  = 100;
    localparam int MEAN_LO  = -100;
    localparam int P2P_LO   = 1950;
    localparam int CONFIRM  = 3;

    typedef enum logic [1:0] {
        HEALTHY = 2'b00,
        BEARING = 2'b01,
        ROTOR   = 2'b10,
        STATOR  = 2'b11
    } fault_e;

    // A collapsed swing means rotor, whatever the mean.
    function automatic fault_e classify(input logic signed [SAMPLE_W-1:0] mean,
                                        input logic [SAMPLE_W:0]          p2p,
                                        input int                         mean_hi,
                                        input int                         mean_lo,
                                        input int                         p2p_lo);
        fault_e res;
        if (int'(p2p) < p2p_lo)        res = ROTOR;
        else if (int'(mean) > mean_hi) res = BEARING;
        else if (int'(mean) < mean_lo) res = STATOR;
        else                           res = HEALTHY;
        return res;
    endfunction

endpackage

// File: rtl/motor_fault_classifier_if.sv
// Sample stream in, window features and debounced fault code out.
// sample_valid has no back-pressure: every asserted cycle is accepted.
interface motor_fault_classifier_if;
    import motor_fault_pkg::*;

    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample;
    logic                       clear;
    logic                       class_valid;
    logic [1:0]                 class_code;
    logic signed [SAMPLE_W-1:0] mean_out;
    logic [SAMPLE_W:0]          p2p_out;
    logic [1:0]                 fault_code;
    logic                       fault_flag;
    logic [1:0]                 dbg_cand;
    logic [7:0]                 dbg_cnt;

    modport master (
        output sample_valid, sample, clear,
        input  class_valid, class_code, mean_out, p2p_out, fault_code, fault_flag,
        input  dbg_cand, dbg_cnt
    );

    modport slave (
        input  sample_valid, sample, clear,
        output class_valid, class_code, mean_out, p2p_out, fault_code, fault_flag,
        output dbg_cand, dbg_cnt
    );

endinterface

// File: rtl/motor_window_stats.sv
// Per-window sample count, signed sum and min/max tracking.
// win_done_o and the *_o values describe the window closing on this cycle's sample.
module motor_window_stats
    import motor_fault_pkg::*;
#(
    parameter int WIN_LOG2_P = WIN_LOG2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  sample_valid_i,
    input  logic signed [SAMPLE_W-1:0]            sample_i,
    input  logic                                  clear_i,
    output logic                                  win_done_o,
    output logic signed [SAMPLE_W+WIN_LOG2_P-1:0] sum_o,
    output logic signed [SAMPLE_W-1:0]            min_o,
    output logic signed [SAMPLE_W-1:0]            max_o
);

    localparam int SUM_W = SAMPLE_W + WIN_LOG2_P;
    localparam int CNT_W = WIN_LOG2_P;

    logic [CNT_W-1:0]           count_q, count_d;
    logic signed [SUM_W-1:0]    sum_q, sum_d, sum_nx;
    logic signed [SAMPLE_W-1:0] min_q, min_d, min_nx;
    logic signed [SAMPLE_W-1:0] max_q, max_d, max_nx;
    logic                       first;
    logic                       done;

    always_comb begin
        // A sample arriving with clear starts the new window, so it loads directly.
        first   = clear_i || (count_q == '0);
        sum_nx  = first ? SUM_W'(sample_i) : sum_q + SUM_W'(sample_i);
        min_nx  = (first || (sample_i < min_q)) ? sample_i : min_q;
        max_nx  = (first || (sample_i > max_q)) ? sample_i : max_q;
        done    = sample_valid_i && !clear_i && (count_q == '1);

        count_d = count_q;
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        if (clear_i) begin
            count_d = '0;
            sum_d   = '0;
            min_d   = '0;
            max_d   = '0;
        end
        if (sample_valid_i) begin
            if (done) begin
                count_d = '0;
                sum_d   = '0;
                min_d   = '0;
                max_d   = '0;
            end else begin
                count_d = clear_i ? CNT_W'(1) : count_q + CNT_W'(1);
                sum_d   = sum_nx;
                min_d   = min_nx;
                max_d   = max_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
        end else begin
            count_q <= count_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
        end
    end

    assign win_done_o = done;
    assign sum_o      = sum_nx;
    assign min_o      = min_nx;
    assign max_o      = max_nx;

endmodule

// File: rtl/motor_fault_classifier.sv
// Window feature extraction, raw classification and debounced fault reporting.
// All outputs are registered; class_valid follows the closing sample by one cycle.
module motor_fault_classifier
    import motor_fault_pkg::*;
#(
    parameter int WIN_LOG2_P = WIN_LOG2,
    parameter int MEAN_HI_P  = MEAN_HI,
    parameter int MEAN_LO_P  = MEAN_LO,
    parameter int P2P_LO_P   = P2P_LO,
    parameter int CONFIRM_P  = CONFIRM
) (
    input  logic                     clk,
    input  logic                     rst,
    motor_fault_classifier_if.slave  bus
);

    localparam int SUM_W = SAMPLE_W + WIN_LOG2_P;
    localparam int CNT_W = $clog2(CONFIRM_P + 1);

    logic                       win_done;
    logic signed [SUM_W-1:0]    win_sum;
    logic signed [SAMPLE_W-1:0] win_min, win_max;
    logic signed [SAMPLE_W-1:0] mean_w;
    logic [SAMPLE_W:0]          p2p_w;
    fault_e                     raw;

    logic                       class_valid_q, class_valid_d;
    fault_e                     class_q, class_d;
    logic signed [SAMPLE_W-1:0] mean_q, mean_d;
    logic [SAMPLE_W:0]          p2p_q, p2p_d;
    fault_e                     cand_q, cand_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    fault_e                     fault_q, fault_d;

    motor_window_stats #(.WIN_LOG2_P(WIN_LOG2_P)) u_stats (
        .clk            (clk),
        .rst            (rst),
        .sample_valid_i (bus.sample_valid),
        .sample_i       (bus.sample),
        .clear_i        (bus.clear),
        .win_done_o     (win_done),
        .sum_o          (win_sum),
        .min_o          (win_min),
        .max_o          (win_max)
    );

    always_comb begin
        mean_w = SAMPLE_W'(win_sum >>> WIN_LOG2_P);
        // Sign-extend before subtracting so the full 17-bit swing is kept.
        p2p_w  = {win_max[SAMPLE_W-1], win_max} - {win_min[SAMPLE_W-1], win_min};
        raw    = classify(mean_w, p2p_w, MEAN_HI_P, MEAN_LO_P, P2P_LO_P);
    end

    always_comb begin
        class_valid_d = win_done;
        class_d       = class_q;
        mean_d        = mean_q;
        p2p_d         = p2p_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        fault_d       = fault_q;
        if (win_done) begin
            class_d = raw;
            mean_d  = mean_w;
            p2p_d   = p2p_w;
            if (raw == cand_q) begin
                if (cnt_q != CNT_W'(CONFIRM_P)) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cand_d = raw;
                cnt_d  = CNT_W'(1);
            end
            if (cnt_d == CNT_W'(CONFIRM_P)) fault_d = cand_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            class_valid_q <= 1'b0;
            class_q       <= HEALTHY;
            mean_q        <= '0;
            p2p_q         <= '0;
            cand_q        <= HEALTHY;
            cnt_q         <= '0;
            fault_q       <= HEALTHY;
        end else begin
            class_valid_q <= class_valid_d;
            class_q       <= class_d;
            mean_q        <= mean_d;
            p2p_q         <= p2p_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.class_valid = class_valid_q;
    assign bus.class_code  = class_q;
    assign bus.mean_out    = mean_q;
    assign bus.p2p_out     = p2p_q;
    assign bus.fault_code  = fault_q;
    assign bus.fault_flag  = (fault_q != HEALTHY);
    assign bus.dbg_cand    = cand_q;
    assign bus.dbg_cnt     = 8'(cnt_q);

endmodule

// File: tb/tb_motor_fault_classifier.sv
// Directed bench: generator-style windows drive a scoreboard of expected
// per-window features and fault codes, checked when class_valid pulses.
module tb_motor_fault_classifier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // {fault[36:35], class[34:33], mean[32:17], p2p[16:0]}
    logic [36:0] exp_q[$];
    int          exp_cyc_q[$];

    motor_fault_classifier_if bus ();

    motor_fault_classifier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lut(input int idx);
        case (idx)
            0: return 0;      1: return 383;    2: return 707;    3: return 924;
            4: return 1000;   5: return 924;    6: return 707;    7: return 383;
            8: return 0;      9: return -383;   10: return -707;  11: return -924;
            12: return -1000; 13: return -924;  14: return -707;  default: return -383;
        endcase
    endfunction

    // kind: 0 healthy, 1 bearing, 2 rotor, 3 stator
    function automatic int sample_val(input int kind, input int idx);
        case (kind)
            1: return lut(idx) + 200;
            2: return lut(idx) + idx * 20;
            3: return lut(idx) - 300;
            default: return lut(idx);
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.sample_valid = 1'b0;
            bus.clear        = 1'b0;
        end
    endtask

    task automatic drive_partial(input int kind, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            bus.sample_valid = 1'b1;
            bus.clear        = 1'b0;
            bus.sample       = 16'(sample_val(kind, k % 16));
        end
    endtask

    task automatic drive_window(input int kind, input int phase, input bit clear_first,
                                input logic [1:0] ec, input int em, input int ep,
                                input logic [1:0] ef);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            bus.sample_valid = 1'b1;
            bus.clear        = clear_first && (k == 0);
            bus.sample       = 16'(sample_val(kind, (phase + k) % 16));
        end
        exp_q.push_back({ef, ec, 16'(em), 17'(ep)});
        exp_cyc_q.push_back(cyc + 1);
    endtask

    task automatic check_zero(input string tag);
        checks += 6;
        assert (bus.class_valid === 1'b0) else begin
            errors++; $error("FAIL %s class_valid got %0b want 0", tag, bus.class_valid); end
        assert (bus.class_code === 2'b00) else begin
            errors++; $error("FAIL %s class_code got %0b want 00", tag, bus.class_code); end
        assert (bus.mean_out === 16'sd0) else begin
            errors++; $error("FAIL %s mean_out got %0d want 0", tag, bus.mean_out); end
        assert (bus.p2p_out === 17'd0) else begin
            errors++; $error("FAIL %s p2p_out got %0d want 0", tag, bus.p2p_out); end
        assert (bus.fault_code === 2'b00) else begin
            errors++; $error("FAIL %s fault_code got %0b want 00", tag, bus.fault_code); end
        assert (bus.fault_flag === 1'b0) else begin
            errors++; $error("FAIL %s fault_flag got %0b want 0", tag, bus.fault_flag); end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.class_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++; $error("FAIL unexpected_pulse at cycle %0d, none expected", cyc); end
            if (exp_q.size() != 0) begin
                logic [36:0] e;
                int          ecyc;
                e    = exp_q.pop_front();
                ecyc = exp_cyc_q.pop_front();
                checks += 6;
                assert (cyc === ecyc) else begin
                    errors++; $error("FAIL latency pulse cycle %0d want %0d", cyc, ecyc); end
                assert (bus.class_code === e[34:33]) else begin
                    errors++; $error("FAIL class_code got %0b want %0b", bus.class_code, e[34:33]); end
                assert (bus.mean_out === e[32:17]) else begin
                    errors++; $error("FAIL mean_out got %0d want %0d", bus.mean_out, $signed(e[32:17])); end
                assert (bus.p2p_out === e[16:0]) else begin
                    errors++; $error("FAIL p2p_out got %0d want %0d", bus.p2p_out, e[16:0]); end
                assert (bus.fault_code === e[36:35]) else begin
                    errors++; $error("FAIL fault_code got %0b want %0b", bus.fault_code, e[36:35]); end
                assert (bus.fault_flag === (e[36:35] != 2'b00)) else begin
                    errors++; $error("FAIL fault_flag got %0b want %0b", bus.fault_flag, e[36:35] != 2'b00); end
            end
        end
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.clear        = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Healthy stream, 4 windows
        for (int w = 0; w < 4; w++) drive_window(0, 0, 1'b0, 2'b00, 0, 2000, 2'b00);

        // Stator, healthy, stator: never three in a row
        drive_window(3, 0, 1'b0, 2'b11, -300, 2000, 2'b00);
        drive_window(0, 0, 1'b0, 2'b00, 0, 2000, 2'b00);
        drive_window(3, 0, 1'b0, 2'b11, -300, 2000, 2'b00);

        // Bearing: fault changes on the third window
        drive_window(1, 0, 1'b0, 2'b01, 200, 2000, 2'b00);
        drive_window(1, 0, 1'b0, 2'b01, 200, 2000, 2'b00);
        drive_window(1, 0, 1'b0, 2'b01, 200, 2000, 2'b01);

        // Rotor starting at phase 5
        drive_window(2, 5, 1'b0, 2'b10, 150, 1840, 2'b01);
        drive_window(2, 5, 1'b0, 2'b10, 150, 1840, 2'b01);
        drive_window(2, 5, 1'b0, 2'b10, 150, 1840, 2'b10);
        idle(3);

        // Clear mid-window (alone, then with a sample) discards partial windows
        drive_partial(3, 7);
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        bus.clear        = 1'b1;
        drive_partial(3, 3);
        drive_window(0, 0, 1'b1, 2'b00, 0, 2000, 2'b10);
        idle(3);

        // Reach stator, then reset mid-window
        drive_window(3, 0, 1'b0, 2'b11, -300, 2000, 2'b10);
        drive_window(3, 0, 1'b0, 2'b11, -300, 2000, 2'b10);
        drive_window(3, 0, 1'b0, 2'b11, -300, 2000, 2'b11);
        drive_partial(0, 5);
        checks++;
        assert (bus.fault_code === 2'b11) else begin
            errors++; $error("FAIL pre_reset_fault got %0b want 11", bus.fault_code); end
        @(posedge clk); #1;
        rst              = 1'b1;
        bus.sample_valid = 1'b0;
        @(posedge clk); #1;
        check_zero("mid_reset");
        rst = 1'b0;
        drive_window(0, 3, 1'b0, 2'b00, 0, 2000, 2'b00);
        idle(4);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++; $error("FAIL missing_pulses got %0d outstanding want 0", exp_q.size()); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
